// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the processor load/store interface. A single-word request
//   (address, store data, byte enables, direction) is captured on a
//   valid/ready handshake. After WAIT_STATES stall cycles the word is read or
//   the enabled byte lanes are written, and a one-cycle response strobe is
//   returned together with load data or an error flag.
//
//   Timing, with the request accepted on edge N:
//     WAIT_STATES > 0 : WAIT for WAIT_STATES cycles, then RESP for one cycle
//     WAIT_STATES = 0 : straight to RESP
//     The RAM is read (or written) on the edge that leaves RESP. The response
//     outputs are registered there, so resp_valid is high in the cycle after
//     RESP (edge N+WAIT_STATES+1). req_ready stays low through that cycle as
//     well, which spaces accepted requests by at least WAIT_STATES+2 cycles.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data
//   req_be     in   4   byte enables, bit i selects lane [8i+7:8i]
//   resp_valid out  1   single-cycle response strobe
//   resp_rdata out  32  load data, zero for stores, errors and outside a response
//   resp_err   out  1   misaligned or out-of-range access
// ----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW      = $clog2(DEPTH_WORDS);
   localparam int unsigned WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic        accept;

   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_be;

   logic        ready_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;

   logic [31:0] mem [DEPTH_WORDS];

   // Offset from the base address, one bit wider so bit 32 is the borrow
   // flagging an address below BASE_ADDR. Because BASE_ADDR is aligned to the
   // RAM size, the bits above the word index are nonzero exactly when the
   // address lies at or beyond the top of the RAM, and bits [1:0] are the
   // misalignment of the original address.
   logic [32:0]   offset;
   logic          addr_err;
   logic [AW-1:0] word_idx;

   assign offset   = {1'b0, cap_addr} - {1'b0, BASE_ADDR};
   assign addr_err = offset[32] | (|offset[31:AW+2]) | (|offset[1:0]);
   assign word_idx = offset[AW+1:2];

   assign accept = req_valid && ready_q;

   // State register.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_next = ST_RESP;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = 4'(WS_LOAD);
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Request capture: the request inputs are don't-care after acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_we    <= 1'b0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
         cap_be    <= 4'd0;
      end else if (accept) begin
         cap_we    <= req_we;
         cap_addr  <= req_addr;
         cap_wdata <= req_wdata;
         cap_be    <= req_be;
      end
   end

   // Registered response and ready. Ready is held low in the cycle that
   // carries resp_valid, even though the FSM is already back in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         ready_q      <= (state_next == ST_IDLE) && (state != ST_RESP);
         resp_valid_q <= (state == ST_RESP);
         resp_err_q   <= (state == ST_RESP) && addr_err;
         if ((state == ST_RESP) && !cap_we && !addr_err) begin
            resp_rdata_q <= mem[word_idx];
         end else begin
            resp_rdata_q <= 32'd0;
         end
      end
   end

   // RAM write of the enabled lanes on the edge leaving RESP. A reset during
   // WAIT or RESP forces the FSM to IDLE first, so such a store never lands.
   // NOTE: the RAM array has no reset; clearing it would turn the storage into
   // flops and its contents are undefined until written anyway.
   always_ff @(posedge clk) begin
      if ((state == ST_RESP) && cap_we && !addr_err) begin
         for (int i = 0; i < 4; i++) begin
            if (cap_be[i]) begin
               mem[word_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. A WAIT_STATES=2 instance runs a table
//   of load/store vectors with hand-computed results; a WAIT_STATES=0
//   instance covers single-cycle latency and ready spacing. Hand-written
//   sequences cover reset behaviour, including reset during a pending store.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk;
   logic        reset;

   // WAIT_STATES = 2 instance
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   // WAIT_STATES = 0 instance
   logic        req_valid0, req_ready0, req_we0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_be0;
   logic        resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid0),
      .req_ready  (req_ready0),
      .req_we     (req_we0),
      .req_addr   (req_addr0),
      .req_wdata  (req_wdata0),
      .req_be     (req_be0),
      .resp_valid (resp_valid0),
      .resp_rdata (resp_rdata0),
      .resp_err   (resp_err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request to the selected instance and wait for its response.
   // All samples are taken 1 time unit after a rising edge. lat counts edges
   // from the accepting edge to the edge that raises resp_valid; it reaches
   // the bound of 40 if no response ever appears.
   task automatic run_req(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat);
      int n;
      n = 0;
      while ((sel ? req_ready0 : req_ready) !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (sel) begin
         req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_wdata0 = wdata; req_be0 = be;
      end else begin
         req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      end
      @(posedge clk); #1;
      // Scramble the inputs after acceptance to show they were captured.
      if (sel) begin
         req_valid0 = 1'b0; req_we0 = ~we; req_addr0 = ~addr; req_wdata0 = ~wdata; req_be0 = ~be;
      end else begin
         req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
      end
      lat = 0;
      while ((sel ? resp_valid0 : resp_valid) !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = sel ? resp_rdata0 : resp_rdata;
      er = sel ? resp_err0 : resp_err;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      vecs[0]  = '{"st_10_full",    1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{"ld_10_full",    1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{"st_10_lane0",   1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
      vecs[3]  = '{"ld_10_lane0",   1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
      vecs[4]  = '{"st_10_be0",     1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
      vecs[5]  = '{"ld_10_be0",     1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
      vecs[6]  = '{"st_10_lanes13", 1'b1, 32'h10,  32'h12345678, 4'hA, 32'h0,        1'b0};
      vecs[7]  = '{"ld_10_lanes13", 1'b0, 32'h10,  32'h0,        4'hF, 32'h12AD56AA, 1'b0};
      vecs[8]  = '{"st_00",         1'b1, 32'h0,   32'h11111111, 4'hF, 32'h0,        1'b0};
      vecs[9]  = '{"st_100_oor",    1'b1, 32'h100, 32'h55555555, 4'hF, 32'h0,        1'b1};
      vecs[10] = '{"ld_00_after",   1'b0, 32'h0,   32'h0,        4'hF, 32'h11111111, 1'b0};
      vecs[11] = '{"ld_12_misal",   1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1};
      vecs[12] = '{"st_fc_top",     1'b1, 32'hFC,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
      vecs[13] = '{"ld_fc_top",     1'b0, 32'hFC,  32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
      vecs[14] = '{"st_13_misal",   1'b1, 32'h13,  32'h99999999, 4'hF, 32'h0,        1'b1};
      vecs[15] = '{"ld_10_after",   1'b0, 32'h10,  32'h0,        4'hF, 32'h12AD56AA, 1'b0};
      vecs[16] = '{"ld_100_oor",    1'b0, 32'h100, 32'h0,        4'hF, 32'h0,        1'b1};
      vecs[17] = '{"st_20",         1'b1, 32'h20,  32'h00001234, 4'hF, 32'h0,        1'b0};
      vecs[18] = '{"ld_20",         1'b0, 32'h20,  32'h0,        4'hF, 32'h00001234, 1'b0};

      reset = 1'b1;
      req_valid  = 1'b0; req_we  = 1'b0; req_addr  = '0; req_wdata  = '0; req_be  = '0;
      req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;

      // Reset held for 3 cycles with a request pending: no ready, no response.
      #2 reset = 1'b0;
      req_valid  = 1'b1;
      req_valid0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("rst_ready_c%0d", i), req_ready, 1'b0);
         check($sformatf("rst_valid_c%0d", i), resp_valid, 1'b0);
      end
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", resp_err, 1'b0);
      check("rst_ready_ws0", req_ready0, 1'b0);
      reset = 1'b1;
      req_valid  = 1'b0;
      req_valid0 = 1'b0;
      @(posedge clk); #1;
      check("rel_ready", req_ready, 1'b1);
      check("rel_ready_ws0", req_ready0, 1'b1);
      check("rel_valid", resp_valid, 1'b0);

      // Table of requests against the WAIT_STATES=2 instance.
      for (int i = 0; i < 19; i++) begin
         run_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         check({vecs[i].name, "_err"}, er, vecs[i].exp_err);
         check({vecs[i].name, "_ready_in_resp"}, req_ready, 1'b0);
         @(posedge clk); #1;
         check({vecs[i].name, "_valid_1cyc"}, resp_valid, 1'b0);
         check({vecs[i].name, "_rdata_idle"}, resp_rdata, 32'h0);
      end

      // WAIT_STATES=0: response one edge after accept, ready back one edge later.
      run_req(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      check("ws0_st_lat", 32'(lat), 32'd1);
      check("ws0_st_err", er, 1'b0);
      check("ws0_st_ready_low", req_ready0, 1'b0);
      @(posedge clk); #1;
      check("ws0_st_ready_high", req_ready0, 1'b1);
      check("ws0_st_valid_drop", resp_valid0, 1'b0);
      run_req(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
      check("ws0_ld_lat", 32'(lat), 32'd1);
      check("ws0_ld_rdata", rd, 32'hA5A5A5A5);
      check("ws0_ld_ready_low", req_ready0, 1'b0);

      // Reset during WAIT of a store to 0x20: no response, old data survives.
      @(posedge clk); #1;
      check("mid_pre_ready", req_ready, 1'b1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBBBBBBBB; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("mid_rst_ready", req_ready, 1'b0);
      check("mid_rst_valid", resp_valid, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check($sformatf("mid_hold_valid_c%0d", i), resp_valid, 1'b0);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("mid_post_valid_c%0d", i), resp_valid, 1'b0);
      end
      run_req(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
      check("mid_ld_lat", 32'(lat), 32'd3);
      check("mid_ld_rdata", rd, 32'h00001234);
      check("mid_ld_err", er, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
